reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for the IDU, successor to the 2R/1W file.
//  - Configurable read/write port counts, register depth and optional hardwired zero register.
//  - Same-cycle write-to-read bypass and an optional registered-read stage.
//  - Per-register busy scoreboard (set at issue, cleared at writeback) so decode can detect RAW hazards.

---
 rtl/reg_file_mp_if.sv | 30 +++
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, writeback ports and the issue strobe
// that marks a destination busy.
interface reg_file_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NUM_RD-1:0]      rd_en;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, optional
// registered read stage and a per-register busy scoreboard for RAW detection.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_RD   = 0
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]        regs [NREGS];
    logic [NREGS-1:0]       busy;
    logic [NREGS-1:0]       wr_hit;
    logic [NUM_RD*XLEN-1:0] rd_data_c;
    logic [NUM_RD-1:0]      rd_busy_c;

    // Out-of-range addresses never match any index, so they drop out naturally.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (!(ZERO_REG != 0 && r == 0)) begin
                    // Later ports overwrite earlier ones, so the highest index wins.
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r)) begin
                            regs[r] <= bus.wr_data[w*XLEN +: XLEN];
                        end
                    end
                    if (bus.iss_en && bus.iss_addr == AW'(r)) begin
                        busy[r] <= 1'b1;
                    end else if (wr_hit[r]) begin
                        busy[r] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en[p]) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (bus.rd_addr[p*AW +: AW] == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
                        rd_data_c[p*XLEN +: XLEN] = regs[r];
                        rd_busy_c[p]              = busy[r];
                        // A register written back this cycle reads the new value, not busy.
                        if (BYPASS != 0) begin
                            for (int w = 0; w < NUM_WR; w++) begin
                                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == AW'(r)) begin
                                    rd_data_c[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
                                    rd_busy_c[p]              = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bus.rd_data <= '0;
                    bus.rd_busy <= '0;
                end else begin
                    bus.rd_data <= rd_data_c;
                    bus.rd_busy <= rd_busy_c;
                end
            end
        end else begin : g_comb_rd
            assign bus.rd_data = rd_data_c;
            assign bus.rd_busy = rd_busy_c;
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: three configurations share one stimulus
// stream and are compared against an array-based reference model.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = bypass/comb/zero-reg, 1 = same but registered read,
    // 2 = 24 registers, no bypass, no zero register.
    logic [31:0] m_regs [3][32];
    logic        m_busy [3][32];
    int          cfg_nregs [3] = '{32, 32, 24};
    int          cfg_zero  [3] = '{1, 1, 0};
    int          cfg_byp   [3] = '{1, 1, 0};
    logic [63:0] u1_exp_d = '0;
    logic [1:0]  u1_exp_b = '0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) if0 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) if1 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(24), .NUM_RD(2), .NUM_WR(2)) if2 ();

    assign if0.rd_en = rd_en;     assign if1.rd_en = rd_en;     assign if2.rd_en = rd_en;
    assign if0.rd_addr = rd_addr; assign if1.rd_addr = rd_addr; assign if2.rd_addr = rd_addr;
    assign if0.wr_en = wr_en;     assign if1.wr_en = wr_en;     assign if2.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr; assign if2.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data; assign if2.wr_data = wr_data;
    assign if0.iss_en = iss_en;   assign if1.iss_en = iss_en;   assign if2.iss_en = iss_en;
    assign if0.iss_addr = iss_addr; assign if1.iss_addr = iss_addr; assign if2.iss_addr = iss_addr;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1), .REG_RD(0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1), .REG_RD(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    reg_file_mp #(.XLEN(32), .NREGS(24), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0), .REG_RD(0))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_valid(input int i, input logic [4:0] a);
        return (int'(a) < cfg_nregs[i]) && !(cfg_zero[i] != 0 && a == 5'd0);
    endfunction

    // What a combinational read would show right now for instance i.
    task automatic modelRead(input int i, output logic [63:0] d, output logic [1:0] b);
        logic [4:0] a;
        d = '0;
        b = '0;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            if (rd_en[p] && model_valid(i, a)) begin
                d[p*32 +: 32] = m_regs[i][a];
                b[p]          = m_busy[i][a];
                if (cfg_byp[i] != 0) begin
                    for (int w = 0; w < 2; w++) begin
                        if (wr_en[w] && wr_addr[w*5 +: 5] == a) begin
                            d[p*32 +: 32] = wr_data[w*32 +: 32];
                            b[p]          = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic modelEdge(input int i);
        bit written [32];
        logic [4:0] a;
        for (int r = 0; r < 32; r++) written[r] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            a = wr_addr[w*5 +: 5];
            if (wr_en[w] && model_valid(i, a)) begin
                m_regs[i][a] = wr_data[w*32 +: 32];
                written[a]   = 1'b1;
            end
        end
        for (int r = 0; r < 32; r++) if (written[r]) m_busy[i][r] = 1'b0;
        if (iss_en && model_valid(i, iss_addr)) m_busy[i][iss_addr] = 1'b1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < 3; i++)
            for (int r = 0; r < 32; r++) begin
                m_regs[i][r] = '0;
                m_busy[i][r] = 1'b0;
            end
        u1_exp_d = '0;
        u1_exp_b = '0;
    endtask

    task automatic setReset(input logic v);
        rst = v;
        if (v) modelClear();
    endtask

    // Checks all instances mid-cycle, then advances the model across one rising edge.
    task automatic applyStimulus();
        logic [63:0] d;
        logic [1:0]  b;
        logic [63:0] nd1;
        logic [1:0]  nb1;
        @(negedge clk);
        modelRead(0, d, b);
        checkOutput("u0_rd_data", if0.rd_data, d);
        checkOutput("u0_rd_busy", {62'd0, if0.rd_busy}, {62'd0, b});
        modelRead(2, d, b);
        checkOutput("u2_rd_data", if2.rd_data, d);
        checkOutput("u2_rd_busy", {62'd0, if2.rd_busy}, {62'd0, b});
        checkOutput("u1_rd_data", if1.rd_data, u1_exp_d);
        checkOutput("u1_rd_busy", {62'd0, if1.rd_busy}, {62'd0, u1_exp_b});
        modelRead(1, nd1, nb1);
        @(posedge clk);
        if (!rst) begin
            u1_exp_d = nd1;
            u1_exp_b = nb1;
            for (int i = 0; i < 3; i++) modelEdge(i);
        end
        #1;
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    function automatic logic [4:0] rndAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        modelClear();
        idle();
        @(posedge clk);
        #1;
        // Reset state seen on all ports
        rd_en = 2'b11; rd_addr = {5'd2, 5'd1};
        #2;
        checkOutput("reset_data", if0.rd_data, 64'd0);
        checkOutput("reset_busy_reg", {62'd0, if1.rd_busy}, 64'd0);
        applyStimulus();
        setReset(1'b0);
        applyStimulus();

        // Same-cycle bypass vs no-bypass
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
        #2;
        checkOutput("bypass_same_cycle", {32'd0, if0.rd_data[31:0]}, 64'hDEADBEEF);
        checkOutput("nobypass_old", {32'd0, if2.rd_data[31:0]}, 64'd0);
        applyStimulus();
        wr_en = 2'b00;
        #2;
        checkOutput("nobypass_next", {32'd0, if2.rd_data[31:0]}, 64'hDEADBEEF);
        checkOutput("regrd_bypass", {32'd0, if1.rd_data[31:0]}, 64'hDEADBEEF);
        applyStimulus();

        // Zero register ignores writes and issues
        idle();
        wr_en = 2'b01; wr_addr = 10'd0; wr_data = {32'd0, 32'h1234};
        iss_en = 1'b1; iss_addr = 5'd0;
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = 10'd0;
        #2;
        checkOutput("x0_data", {32'd0, if0.rd_data[31:0]}, 64'd0);
        checkOutput("x0_busy", {63'd0, if0.rd_busy[0]}, 64'd0);
        applyStimulus();

        // Two write ports to one register: port 1 wins
        idle();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        #2;
        checkOutput("x7_port1_wins", {32'd0, if0.rd_data[31:0]}, 64'h22);
        applyStimulus();

        // Scoreboard: issue priority over writeback
        idle();
        iss_en = 1'b1; iss_addr = 5'd3;
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        #2;
        checkOutput("x3_busy_after_issue", {63'd0, if0.rd_busy[0]}, 64'd1);
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h55};
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        #2;
        checkOutput("x3_busy_stays", {63'd0, if0.rd_busy[0]}, 64'd1);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h66};
        #1;
        checkOutput("x3_wb_not_busy", {63'd0, if0.rd_busy[0]}, 64'd0);
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        #2;
        checkOutput("x3_cleared", {63'd0, if0.rd_busy[0]}, 64'd0);
        checkOutput("x3_data", {32'd0, if0.rd_data[31:0]}, 64'h66);
        applyStimulus();

        // Registered read latency and mid-stream reset
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'd0, 32'hA5A5A5A5};
        applyStimulus();
        idle();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
        #2;
        checkOutput("regrd_not_yet", {32'd0, if1.rd_data[31:0]}, 64'd0);
        applyStimulus();
        #1;
        checkOutput("regrd_latency", {32'd0, if1.rd_data[31:0]}, 64'hA5A5A5A5);
        iss_en = 1'b1; iss_addr = 5'd9;
        applyStimulus();
        iss_en = 1'b0;
        setReset(1'b1);
        #2;
        checkOutput("regrd_reset_data", if1.rd_data, 64'd0);
        checkOutput("reset_busy_clear", {62'd0, if0.rd_busy}, 64'd0);
        applyStimulus();
        setReset(1'b0);

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rd_en    = 2'($urandom);
            rd_addr  = {rndAddr(), rndAddr()};
            wr_en    = 2'($urandom);
            wr_addr  = {rndAddr(), rndAddr()};
            wr_data  = {$urandom, $urandom};
            iss_en   = 1'($urandom);
            iss_addr = rndAddr();
            if ($urandom_range(0, 79) == 0) begin
                wr_en  = '0;
                iss_en = 1'b0;
                setReset(1'b1);
                applyStimulus();
                setReset(1'b0);
            end else begin
                applyStimulus();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
